// File: rtl/binary_to_bcd_serial_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
// The sizing function lets the top refuse a digit count that cannot hold the largest input.
package binary_to_bcd_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to print 2**in_w - 1.
  function automatic int min_bcd_digits(input int in_w);
    longint max_v;
    int     d;
    max_v = (longint'(1) << in_w) - longint'(1);
    d     = 32'sd1;
    for (int i = 32'sd0; i < 32'sd20; i++) begin
      if (max_v >= longint'(10)) begin
        max_v = max_v / longint'(10);
        d     = d + 32'sd1;
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/binary_to_bcd_serial_digit_adjust.sv
// One double-dabble correction cell: a nibble of 5 or more gets 3 added before the shift.
// The result never exceeds 4'hC, so no carry leaves the nibble.
module bcd_digit_adjust
  import binary_to_bcd_serial_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/binary_to_bcd_serial.sv
// Iterative shift-add-3 converter: accepts a binary value, shifts one bit per clock
// through a {BCD, BIN} register, and presents the packed digits until taken downstream.
module binary_to_bcd_serial
  import binary_to_bcd_serial_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  if (DIGITS < min_bcd_digits(IN_W)) begin : g_digits_check
    $error("binary_to_bcd_serial: DIGITS too small for IN_W");
  end

  state_e             state_r;
  logic [SR_W-1:0]    shift_r;
  logic [CNT_W-1:0]   count_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [BCD_W-1:0]   out_bcd_r;
  logic [BCD_W-1:0]   adj_s;
  logic [SR_W-1:0]    shift_nxt_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shift_r[IN_W + 4*g +: 4]),
      .adjusted (adj_s[4*g +: 4])
    );
  end

  // The top bit of the adjusted field is always zero when DIGITS is large enough.
  assign shift_nxt_s = {adj_s, shift_r[IN_W-1:0]} << 1;

  // Handshake FSM, bit counter and the shift register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_bcd_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            shift_r    <= {{BCD_W{1'b0}}, in_bin};
            count_r    <= CNT_W'(IN_W);
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          shift_r <= shift_nxt_s;
          count_r <= count_r - CNT_W'(1);
          if (count_r == CNT_W'(1)) begin
            out_bcd_r   <= shift_nxt_s[SR_W-1 -: BCD_W];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_bcd   = out_bcd_r;

endmodule

// File: doc/binary_to_bcd_serial.md
Name: binary_to_bcd_serial

Overview:
- Sequential binary-to-BCD converter using iterative shift-add-3 (double-dabble).
- Sits directly downstream of the binary adder.
- Takes the adder's binary sum and produces packed decimal digits for display and decimal-domain logic.
- Uses a valid/ready handshake on both sides and converts one bit per clock.

Parameters:
- IN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Elaboration error if 10**DIGITS - 1 < 2**IN_W - 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bin holds a value to convert.
- in_ready  output  1  converter can accept; high only in IDLE.
- in_bin  input  IN_W  unsigned binary operand.
- out_valid  output  1  out_bcd holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high on rst.
- While rst is high:
  - state = IDLE, out_valid = 0, out_bcd = 0, in_ready = 0.
  - Internal shift register and bit counter are cleared.
- From the first clk edge after rst deasserts: in_ready = 1.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - On an edge with in_valid & in_ready: load the shift register {BCD = 0, BIN = in_bin}, set count = IN_W, go to SHIFT.
  - SHIFT:
    - in_ready = 0.
    - Each edge: every BCD nibble >= 5 gets +3 (all nibbles in parallel, combinational); then the whole {BCD, BIN} register shifts left by 1; count decrements.
    - When count reaches 0 after the edge, go to DONE.
    - Exactly IN_W shift edges.
  - DONE:
    - out_valid = 1, out_bcd = final BCD field.
    - Holds until an edge with out_valid & out_ready, then go to IDLE and out_valid = 0.
- Latency: out_valid rises IN_W edges after the accepting edge (8 for defaults).
- Minimum initiation interval: IN_W + 2 cycles (10 for defaults), because in_ready is low in DONE. No skid or overlap.
- out_bcd is registered and stable for the whole out_valid interval, regardless of in_bin or in_valid activity.
- out_bcd retains its last value after the handshake until the next DONE.
- in_bin is sampled only on the accepting edge; changes at other times are ignored.
- Nibble adjust width: adds are 4-bit, and a nibble >= 5 plus 3 never exceeds 4'hC, so no carry out of the nibble before the shift.
- The DIGITS check guarantees no overflow. There is no saturation logic.
- Boundaries:
  - in_bin = 0 -> all-zero BCD.
  - in_bin = 2**IN_W - 1 -> maximum decimal value.
  - Nibble values > 9 never appear at the output.
- Simultaneous events:
  - in_valid high while in SHIFT or DONE: not accepted and not lost; it is accepted once back in IDLE if still asserted.
  - out_ready high outside DONE: no effect.
- Reset mid-operation (SHIFT or DONE): conversion is aborted, no out_valid pulse follows, and the result is discarded.

Decomposition:
- Shared package holds:
  - state enum typedef {IDLE, SHIFT, DONE};
  - constants BCD_ADJ_THRESH = 4'd5 and BCD_ADJ_ADD = 4'd3;
  - a constant function returning the minimum DIGITS for a given IN_W, used by the parameter check.
- One sub-module, bcd_digit_adjust: 4-bit in, 4-bit out, combinational add-3-if->=5. Instantiated DIGITS times via generate.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle (asynchronous) -> out_valid = 0, out_bcd = 12'h000, in_ready = 0 immediately. After release -> in_ready = 1 on the next edge.
- Conversions: in_bin = 255 -> out_bcd = 12'h255 eight edges after accept. Likewise 0 -> 12'h000, 99 -> 12'h099, 100 -> 12'h100, 9 -> 12'h009, 10 -> 12'h010.
- Backpressure: convert 200, hold out_ready = 0 for 5 cycles while in_valid = 1 with in_bin = 42.
  - During the stall: out_bcd stays 12'h200, in_ready stays 0.
  - After out_ready pulses: 42 is accepted and 12'h042 is produced.
- Reset mid-SHIFT: assert rst 4 cycles after accepting 77 -> out_valid never pulses for 77. After reset, 123 -> 12'h123.
- Input stability: accept 50, then toggle in_bin randomly during SHIFT -> out_bcd = 12'h050.
- Throughput sweep: out_ready tied high, in_valid tied high, all 256 values in sequence.
  - Accepts spaced exactly 10 cycles apart.
  - Every result matches a reference decimal model.
